// File: rtl/iopin_sampler.sv
// Pin read-back sampler: synchronizes the raw buffer level, glitch-filters it into dout
// with edge pulses, and flags contention between the driven value and the observed level.
module iopin_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CONT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bufdat_tristate_din,
  input  logic              oe,
  input  logic              od,
  input  logic              dir,
  input  logic              din,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CONT_W-1:0] cont_len,
  input  logic              clear,
  output logic              dout,
  output logic              valid,
  output logic              rise,
  output logic              fall,
  output logic              contention,
  output logic              contention_sticky
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   sync;
  logic                   live;
  logic                   primed;
  logic                   cand_q;
  logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
  logic                   stable, load;

  logic                   driving, expected, mismatch, blank;
  logic                   drv_q, exp_q;
  logic [CONT_W-1:0]      cont_cnt_q, cont_cnt_d;
  logic                   contention_d, sticky_d;

  assign sync   = sync_q[SYNC_STAGES-1];
  // warm_q marks when sync first carries a real pin sample (live) and one cycle later (primed),
  // so the reset contents of the synchronizer are never counted as stable samples.
  assign live   = warm_q[SYNC_STAGES-1];
  assign primed = warm_q[SYNC_STAGES];

  assign driving  = oe & dir & (~od | ~din);
  assign expected = od ? 1'b0 : din;
  assign mismatch = driving & valid & (dout != expected);
  assign blank    = (driving != drv_q) | (expected != exp_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    filt_cnt_d = '0;
    if (live && primed && (sync == cand_q))
      filt_cnt_d = (filt_cnt_q == '1) ? filt_cnt_q : filt_cnt_q + 1'b1;
    stable = live && (filt_cnt_d >= filt_len);
    load   = stable && (!valid || (sync != dout));

    cont_cnt_d = '0;
    if (mismatch && !blank)
      cont_cnt_d = (cont_cnt_q == '1) ? cont_cnt_q : cont_cnt_q + 1'b1;
    contention_d = mismatch && (cont_cnt_d >= cont_len);
    // Setting takes priority over a coincident clear.
    sticky_d     = contention_d || (contention_sticky && !clear);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q            <= '0;
      warm_q            <= '0;
      cand_q            <= 1'b0;
      filt_cnt_q        <= '0;
      dout              <= 1'b0;
      valid             <= 1'b0;
      rise              <= 1'b0;
      fall              <= 1'b0;
      drv_q             <= 1'b0;
      exp_q             <= 1'b0;
      cont_cnt_q        <= '0;
      contention        <= 1'b0;
      contention_sticky <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bufdat_tristate_din};
      warm_q     <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      cand_q     <= sync;
      filt_cnt_q <= filt_cnt_d;
      rise       <= load && valid && sync && !dout;
      fall       <= load && valid && !sync && dout;
      if (load) begin
        dout  <= sync;
        valid <= 1'b1;
      end
      drv_q             <= driving;
      exp_q             <= expected;
      cont_cnt_q        <= cont_cnt_d;
      contention        <= contention_d;
      contention_sticky <= sticky_d;
    end
  end

endmodule

// File: tb/tb_iopin_sampler.sv
// Directed bench for iopin_sampler: filter latency, glitch rejection, edge pulses,
// contention detection/blanking, sticky clear priority and asynchronous reset.
module tb_iopin_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       pin;
  logic       oe, od, dir, din;
  logic [3:0] filt_len;
  logic [3:0] cont_len;
  logic       clear;
  logic       dout, valid, rise, fall, contention, contention_sticky;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  logic cont_seen;

  iopin_sampler #(.SYNC_STAGES(2), .FILT_W(4), .CONT_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bufdat_tristate_din (pin),
    .oe                  (oe),
    .od                  (od),
    .dir                 (dir),
    .din                 (din),
    .filt_len            (filt_len),
    .cont_len            (cont_len),
    .clear               (clear),
    .dout                (dout),
    .valid               (valid),
    .rise                (rise),
    .fall                (fall),
    .contention          (contention),
    .contention_sticky   (contention_sticky)
  );

  always #5 clk = ~clk;

  // Edge pulses are tallied just after each rising edge, so single-cycle pulses are never missed.
  always @(posedge clk) begin
    #1;
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    assert (actual === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [5:0] outs();
    return {dout, valid, rise, fall, contention, contention_sticky};
  endfunction

  initial begin
    rst = 1'b0; pin = 1'b1; oe = 1'b0; od = 1'b0; dir = 1'b0; din = 1'b0;
    filt_len = 4'd3; cont_len = 4'd2; clear = 1'b0;

    // Reset state, then first acceptance after 2 sync + 4 stable cycles, no edge pulse.
    cyc(3);
    check("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b1;
    cyc(5);
    check("first_valid_not_early", 32'(valid), 32'h0);
    cyc(1);
    check("first_valid", 32'(valid), 32'h1);
    check("first_dout", 32'(dout), 32'h1);
    check("first_no_rise", 32'(rise_cnt), 32'h0);

    // Pin falls: accepted on the 6th edge with one fall pulse.
    pin = 1'b0;
    cyc(5);
    check("fall_not_early", 32'(dout), 32'h1);
    cyc(1);
    check("fall_dout", 32'(dout), 32'h0);
    check("fall_pulse", 32'(fall), 32'h1);
    cyc(1);
    check("fall_pulse_one_cycle", 32'(fall), 32'h0);
    check("fall_count", 32'(fall_cnt), 32'h1);

    // 3-cycle glitch is rejected.
    pin = 1'b1;
    cyc(3);
    pin = 1'b0;
    cyc(8);
    check("glitch_dout", 32'(dout), 32'h0);
    check("glitch_no_rise", 32'(rise_cnt), 32'h0);

    // 4-cycle high is accepted with a single rise pulse, then falls back.
    pin = 1'b1;
    cyc(4);
    pin = 1'b0;
    cyc(1);
    check("pulse4_not_early", 32'(dout), 32'h0);
    cyc(1);
    check("pulse4_dout", 32'(dout), 32'h1);
    check("pulse4_rise", 32'(rise), 32'h1);
    cyc(1);
    check("pulse4_rise_count", 32'(rise_cnt), 32'h1);
    cyc(5);
    check("pulse4_back_low", 32'(dout), 32'h0);
    check("pulse4_fall_count", 32'(fall_cnt), 32'h2);

    // Push-pull drive of 1 against a pin held 0: contention on the 3rd edge.
    oe = 1'b1; dir = 1'b1; od = 1'b0; din = 1'b1;
    cyc(2);
    check("cont_not_early", 32'(contention), 32'h0);
    cyc(1);
    check("cont_set", 32'(contention), 32'h1);
    check("cont_sticky_set", 32'(contention_sticky), 32'h1);
    pin = 1'b1;
    cyc(6);
    check("cont_pin_follows", 32'(dout), 32'h1);
    cyc(1);
    check("cont_drop", 32'(contention), 32'h0);
    check("cont_sticky_hold", 32'(contention_sticky), 32'h1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("cont_sticky_clear", 32'(contention_sticky), 32'h0);

    // Open drain releasing (din=1) never flags, even with the pin low.
    od = 1'b1; din = 1'b1; pin = 1'b0;
    cyc(10);
    check("od_release_dout", 32'(dout), 32'h0);
    check("od_release_no_cont", 32'({contention, contention_sticky}), 32'h0);
    pin = 1'b1;
    cyc(8);
    check("od_pin_high", 32'(dout), 32'h1);
    din = 1'b0;
    cyc(2);
    check("od_cont_not_early", 32'(contention), 32'h0);
    cyc(1);
    check("od_cont_set", 32'(contention), 32'h1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("sticky_set_wins", 32'(contention_sticky), 32'h1);

    // Toggling din every cycle keeps the counter blanked.
    od = 1'b0; din = 1'b1;
    cyc(1);
    check("toggle_prep_cont", 32'(contention), 32'h0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("toggle_prep_sticky", 32'(contention_sticky), 32'h0);
    cont_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = ~din;
      cyc(1);
      cont_seen = cont_seen | contention;
    end
    check("toggle_no_cont", 32'({cont_seen, contention_sticky}), 32'h0);

    // Asynchronous reset mid-count with sticky set.
    din = 1'b0;
    cyc(3);
    check("pre_reset_sticky", 32'(contention_sticky), 32'h1);
    pin = 1'b0;
    cyc(3);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs()), 32'h0);
    cyc(2);
    check("held_reset_outs", 32'(outs()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
